// File: rtl/address_mapper_pkg.sv
// Shared definitions for the CPU address mapper: FSM states, data-mux select
// codes, SAM configuration bit positions and special FFxx page bases.
package address_mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_RAM  = 3'b000;
  localparam logic [2:0] SEL_ROM  = 3'b001;
  localparam logic [2:0] SEL_CART = 3'b011;
  localparam logic [2:0] SEL_IO0  = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam int CFG_TY = 15;
  localparam int CFG_R1 = 12;
  localparam int CFG_R0 = 11;

  localparam logic [15:0] CFG_BASE = 16'hFFC0;
  localparam logic [15:0] VEC_BASE = 16'hFFE0;

  localparam logic [1:0] RATE_ALL_SLOW = 2'b00;
  localparam logic [1:0] RATE_RAM_SLOW = 2'b01;

endpackage

// File: rtl/address_mapper_if.sv
// CPU-side access bus of the address mapper: request in, decode results and
// configuration out.
interface address_mapper_if #(
  parameter int ADDR_W = 16,
  parameter int SEL_W  = 3
);
  logic [ADDR_W-1:0] A;
  logic              RnW;
  logic              valid;
  logic [SEL_W-1:0]  S;
  logic              isRAM;
  logic              slowBlock;
  logic              ready;
  logic              busy;
  logic [15:0]       cfg;
  logic              mapType;

  modport master (
    output A, RnW, valid,
    input  S, isRAM, slowBlock, ready, busy, cfg, mapType
  );

  modport slave (
    input  A, RnW, valid,
    output S, isRAM, slowBlock, ready, busy, cfg, mapType
  );
endinterface

// File: rtl/address_mapper_addr_decode.sv
// Purely combinational address decode: select code, DRAM target and access
// rate from the latched address, direction, map type and rate field.
module addr_decode
  import address_mapper_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int SEL_W    = 3,
  parameter int IO_PAGES = 3
) (
  input  logic [ADDR_W-1:0] i_a,
  input  logic              i_rnw,
  input  logic              i_map_type,
  input  logic [1:0]        i_rate,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_is_ram,
  output logic              o_slow
);

  logic       w_ff_page;
  logic       w_hi_half;
  logic       w_io_hit;
  logic       w_io0_hit;
  logic [2:0] w_page;
  logic       w_unused;

  assign w_unused  = ^i_a[4:0];
  assign w_page    = i_a[7:5];
  assign w_ff_page = (i_a[ADDR_W-1 -: 8] == 8'hFF);
  assign w_hi_half = i_a[ADDR_W-1];
  assign w_io_hit  = w_ff_page && (int'(w_page) < IO_PAGES);
  assign w_io0_hit = w_ff_page && (w_page == 3'd0);

  always_comb begin
    o_sel = SEL_W'(SEL_NONE);
    if (w_io_hit) begin
      o_sel = SEL_W'(SEL_IO0) + SEL_W'(w_page);
    end else if (w_ff_page) begin
      o_sel = (w_page == VEC_BASE[7:5]) ? SEL_W'(SEL_ROM) : SEL_W'(SEL_NONE);
    end else if (w_hi_half) begin
      // In map type 1 the upper half is DRAM for writes, ROM/cart stay readable
      if (!i_rnw && i_map_type) begin
        o_sel = SEL_W'(SEL_RAM);
      end else if (!i_a[ADDR_W-2]) begin
        o_sel = SEL_W'(SEL_ROM);
      end else begin
        o_sel = SEL_W'(SEL_CART);
      end
    end else begin
      o_sel = i_rnw ? SEL_W'(SEL_RAM) : SEL_W'(SEL_NONE);
    end
  end

  always_comb begin
    o_is_ram = !w_hi_half || (i_map_type && !w_ff_page);
    o_slow   = 1'b0;
    if (i_rate == RATE_ALL_SLOW) begin
      o_slow = 1'b1;
    end else if (i_rate == RATE_RAM_SLOW) begin
      o_slow = o_is_ram || w_io0_hit;
    end
  end

endmodule

// File: rtl/address_mapper.sv
// CPU address mapper: latches an access, decodes it, inserts slow-rate wait
// cycles and maintains the SAM configuration register written via FFC0-FFDF.
module address_mapper
  import address_mapper_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int SEL_W     = 3,
  parameter int IO_PAGES  = 3,
  parameter int SLOW_WAIT = 2
) (
  input  logic            clk,
  input  logic            nReset,
  address_mapper_if.slave bus
);

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rnw;
  logic [SEL_W-1:0]  r_sel;
  logic              r_is_ram;
  logic              r_slow;
  logic              r_ready;
  logic              r_busy;
  logic [15:0]       r_cfg;

  logic [SEL_W-1:0]  w_sel;
  logic              w_is_ram;
  logic              w_slow;
  logic              w_cfg_hit;
  logic [15:0]       w_cfg_next;

  function automatic logic [15:0] cfg_apply(input logic [15:0] cfg,
                                            input logic        hit,
                                            input logic [3:0]  idx,
                                            input logic        set);
    logic [15:0] f;
    f = cfg;
    if (hit) f[idx] = set;
    return f;
  endfunction

  addr_decode #(
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W),
    .IO_PAGES(IO_PAGES)
  ) u_decode (
    .i_a       (r_addr),
    .i_rnw     (r_rnw),
    .i_map_type(r_cfg[CFG_TY]),
    .i_rate    (r_cfg[CFG_R1:CFG_R0]),
    .o_sel     (w_sel),
    .o_is_ram  (w_is_ram),
    .o_slow    (w_slow)
  );

  assign w_cfg_hit  = !r_rnw && (r_addr[ADDR_W-1 -: 8] == 8'hFF) &&
                      (r_addr[7:5] == CFG_BASE[7:5]);
  assign w_cfg_next = cfg_apply(r_cfg, w_cfg_hit, r_addr[4:1], r_addr[0]);

  // Request capture is data only; the FSM below decides when it is meaningful
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.valid) begin
      r_addr <= bus.A;
      r_rnw  <= bus.RnW;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_sel      <= SEL_W'(SEL_NONE);
      r_is_ram   <= 1'b0;
      r_slow     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_cfg      <= 16'h0000;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.valid) begin
            r_state <= ST_DECODE;
            r_busy  <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_sel    <= w_sel;
          r_is_ram <= w_is_ram;
          r_slow   <= w_slow;
          if (w_slow) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 4'(SLOW_WAIT - 1);
          end else begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_cfg   <= w_cfg_next;
          end
        end
        ST_WAIT: begin
          // The rate used for this access was fixed in DECODE, so a cfg
          // write landing here only affects the following access.
          if (r_wait_cnt == 4'd0) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_cfg   <= w_cfg_next;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.S         = r_sel;
  assign bus.isRAM     = r_is_ram;
  assign bus.slowBlock = r_slow;
  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.cfg       = r_cfg;
  assign bus.mapType   = r_cfg[CFG_TY];

endmodule

// File: tb/tb_address_mapper.sv
// Randomised and directed bench for address_mapper against a range-based
// reference model of the memory map and configuration register.
module tb_address_mapper;

  localparam int SLOW_WAIT = 2;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [15:0] m_cfg = 16'h0000;

  always #5 clk = ~clk;

  address_mapper_if #(.ADDR_W(16), .SEL_W(3)) bus ();
  address_mapper_if #(.ADDR_W(16), .SEL_W(3)) bus2 ();

  address_mapper #(.ADDR_W(16), .SEL_W(3), .IO_PAGES(3), .SLOW_WAIT(SLOW_WAIT)) dut (
    .clk(clk), .nReset(nReset), .bus(bus)
  );

  address_mapper #(.ADDR_W(16), .SEL_W(3), .IO_PAGES(1), .SLOW_WAIT(SLOW_WAIT)) dut_io1 (
    .clk(clk), .nReset(nReset), .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] ref_sel(input logic [15:0] a, input logic rnw,
                                         input logic ty, input int pages);
    int page;
    page = int'(a[7:5]);
    if (a >= 16'hFF00) begin
      if (page < pages) return 3'(4 + page);
      if (a >= 16'hFFE0) return 3'b001;
      return 3'b111;
    end
    if (a >= 16'h8000) begin
      if (!rnw && ty) return 3'b000;
      if (a < 16'hC000) return 3'b001;
      return 3'b011;
    end
    return rnw ? 3'b000 : 3'b111;
  endfunction

  function automatic logic ref_ram(input logic [15:0] a, input logic ty);
    return (a < 16'h8000) || (ty && a < 16'hFF00);
  endfunction

  function automatic logic ref_slow(input logic [15:0] a, input logic [15:0] cfg);
    int rate;
    rate = int'(cfg[12:11]);
    if (rate == 0) return 1'b1;
    if (rate == 1) return ref_ram(a, cfg[15]) || (a >= 16'hFF00 && a < 16'hFF20);
    return 1'b0;
  endfunction

  function automatic logic [15:0] ref_cfg(input logic [15:0] cfg, input logic [15:0] a,
                                          input logic rnw);
    logic [15:0] c;
    int idx;
    c = cfg;
    if (!rnw && a >= 16'hFFC0 && a < 16'hFFE0) begin
      idx = int'(a - 16'hFFC0) / 2;
      c[idx] = a[0];
    end
    return c;
  endfunction

  // Issues one access at the current negedge and checks it through to idle.
  task automatic do_access(input logic [15:0] a, input logic rnw);
    logic [2:0] es;
    logic er, esl;
    int lat, cnt;
    es  = ref_sel(a, rnw, m_cfg[15], 3);
    er  = ref_ram(a, m_cfg[15]);
    esl = ref_slow(a, m_cfg);
    lat = esl ? SLOW_WAIT + 2 : 2;
    bus.A = a; bus.RnW = rnw; bus.valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      bus.valid = 1'b0;
      cnt++;
      if (cnt == 1) check("busy_active", bus.busy, 1);
    end while (!bus.ready && cnt < 40);
    check($sformatf("latency@%h", a), cnt, lat);
    check($sformatf("S@%h", a), bus.S, es);
    check($sformatf("isRAM@%h", a), bus.isRAM, er);
    check($sformatf("slow@%h", a), bus.slowBlock, esl);
    check("busy_done", bus.busy, 0);
    m_cfg = ref_cfg(m_cfg, a, rnw);
    @(negedge clk);
    check("ready_pulse", bus.ready, 0);
    check("cfg", bus.cfg, m_cfg);
    check("mapType", bus.mapType, m_cfg[15]);
  endtask

  initial begin
    int n_rdy, cnt, cat;
    logic [15:0] a;
    logic rnw;
    bus.A = '0; bus.RnW = 1'b1; bus.valid = 1'b0;
    bus2.A = '0; bus2.RnW = 1'b1; bus2.valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_S", bus.S, 3'b111);
    check("rst_isRAM", bus.isRAM, 0);
    check("rst_slow", bus.slowBlock, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg", bus.cfg, 0);
    check("rst_mapType", bus.mapType, 0);
    nReset = 1'b1;
    @(negedge clk);

    do_access(16'h1234, 1'b1);

    // valid held during WAIT must be ignored
    bus.A = 16'h1234; bus.RnW = 1'b1; bus.valid = 1'b1;
    n_rdy = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.valid = (c == 2 || c == 3);
      if (bus.ready) n_rdy++;
    end
    bus.valid = 1'b0;
    check("single_ready", n_rdy, 1);

    // reset in WAIT aborts the FFDF write
    bus.A = 16'hFFDF; bus.RnW = 1'b0; bus.valid = 1'b1;
    @(negedge clk); bus.valid = 1'b0;
    @(negedge clk);
    check("wait_before_rst_busy", bus.busy, 1);
    nReset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.ready, 0);
    check("abort_S", bus.S, 3'b111);
    check("abort_cfg", bus.cfg, 0);
    @(negedge clk); nReset = 1'b1;
    n_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ready) n_rdy++;
    end
    check("abort_no_ready", n_rdy, 0);
    check("abort_cfg_after", bus.cfg, 0);
    m_cfg = 16'h0000;

    do_access(16'hFFD7, 1'b0);
    do_access(16'hFFDF, 1'b0);
    check("cfg11", bus.cfg[11], 1);
    check("cfg15", bus.cfg[15], 1);
    do_access(16'hA000, 1'b0);
    check("A000_S", bus.S, 3'b000);
    check("A000_isRAM", bus.isRAM, 1);

    do_access(16'hFFDE, 1'b0);
    do_access(16'hC000, 1'b1);
    check("C000_S", bus.S, 3'b011);
    check("C000_slow", bus.slowBlock, 0);
    do_access(16'hFF00, 1'b1);
    check("FF00_S", bus.S, 3'b100);
    check("FF00_slow", bus.slowBlock, 1);
    do_access(16'hFF20, 1'b1);
    check("FF20_S", bus.S, 3'b101);
    do_access(16'hFF40, 1'b1);
    check("FF40_S", bus.S, 3'b110);
    do_access(16'hFF60, 1'b1);
    check("FF60_S", bus.S, 3'b111);
    do_access(16'hFFFE, 1'b1);
    check("FFFE_S", bus.S, 3'b001);
    do_access(16'hFFC5, 1'b1);

    // single I/O page build: FF20 falls through to "other FFxx"
    bus2.A = 16'hFF20; bus2.RnW = 1'b1; bus2.valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      bus2.valid = 1'b0;
      cnt++;
    end while (!bus2.ready && cnt < 40);
    check("io1_ready", bus2.ready, 1);
    check("io1_FF20_S", bus2.S, ref_sel(16'hFF20, 1'b1, 1'b0, 1));
    @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      cat = int'($urandom_range(0, 5));
      rnw = 1'($urandom_range(0, 1));
      case (cat)
        0: a = 16'($urandom_range(0, 16'h7FFF));
        1: a = 16'($urandom_range(16'h8000, 16'hBFFF));
        2: a = 16'($urandom_range(16'hC000, 16'hFEFF));
        3: a = 16'($urandom_range(16'hFF00, 16'hFFFF));
        default: begin
          a = 16'hFFC0 + 16'($urandom_range(0, 31));
          rnw = ($urandom_range(0, 3) == 0);
        end
      endcase
      do_access(a, rnw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/address_mapper.md
ADDRESS_MAPPER -- requirements
Module: address_mapper

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU address width; top byte all-ones is the FFxx page.
REQ-002 SHALL have parameter SEL_W, default 3, width of the data-multiplexer select.
REQ-003 SHALL have parameter IO_PAGES, default 3, number of 32-byte I/O pages from FF00 upward (1..3).
REQ-004 SHALL have parameter SLOW_WAIT, default 2, wait cycles for a slow access (1..15).
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 nReset  input  1  asynchronous, active-low reset.
REQ-007 A  input  ADDR_W  CPU address, sampled on valid.
REQ-008 RnW  input  1  1 = read, 0 = write, sampled on valid.
REQ-009 valid  input  1  one-cycle access-start strobe.
REQ-010 S  output  SEL_W  registered multiplexer select.
REQ-011 isRAM  output  1  registered: access targets DRAM.
REQ-012 slowBlock  output  1  registered: access uses the slow rate.
REQ-013 ready  output  1  one-cycle access-complete pulse.
REQ-014 busy  output  1  access in progress.
REQ-015 cfg  output  16  SAM configuration register bits.
REQ-016 mapType  output  1  equals cfg[15] (TY).

Function
REQ-017 FSM states SHALL be IDLE, DECODE, WAIT, DONE.
REQ-018 IDLE: valid=1 latches A and RnW, -> DECODE, busy=1; valid ignored in every other state.
REQ-019 DECODE, one cycle: S, isRAM, slowBlock registered from latched values; -> WAIT if slow, else -> DONE.
REQ-020 WAIT: counter loaded with SLOW_WAIT-1 on entry, decrements each cycle; -> DONE on zero.
REQ-021 DONE: ready=1 for exactly one cycle, busy=0, -> IDLE; S/isRAM/slowBlock hold until next DECODE.
REQ-022 Select priority: I/O page k (k<IO_PAGES, A[7:5]=k in FFxx) -> S=4+k; FFE0-FFFF -> 001; other FFxx -> 111; 8000-FEFF write with mapType=1 -> 000; 8000-BFFF -> 001; C000-FEFF -> 011; below 8000 read -> 000, write -> 111.
REQ-023 isRAM SHALL be 1 when A<8000, or mapType=1 and not FFxx.
REQ-024 Rate field R=cfg[12:11]: 00 all accesses slow; 01 slow only if isRAM or I/O page 0; 1x all fast; slowBlock reflects this.
REQ-025 Write to FFC0-FFDF: bit index A[4:1]; A[0]=0 clears, A[0]=1 sets; takes effect on the DONE cycle; reads of this range change nothing.
REQ-026 Rate change from a write SHALL apply from the next access, never the current one.
REQ-027 Back-to-back: valid in the cycle after DONE SHALL be accepted (minimum access 3 cycles).

Reset
REQ-028 nReset low SHALL immediately force IDLE, S=111, isRAM=0, slowBlock=0, ready=0, busy=0, cfg=0, WAIT counter=0.
REQ-029 Reset mid-WAIT SHALL abort without a ready pulse and without committing a pending cfg write.

Structure
REQ-030 Shared package SHALL hold FSM state encoding, select codes (SEL_RAM=000, SEL_ROM=001, SEL_CART=011, SEL_IO0=100, SEL_NONE=111), cfg bit indices (TY=15, R1=12, R0=11), and the FFC0/FFE0 bases.
REQ-031 Combinational decode SHALL be one sub-module, addr_decode, pure function of (A, RnW, mapType, rate) to (S, isRAM, slow).

Verification
REQ-032 Reset, R=00, read A=1234 -> S=000, isRAM=1, slowBlock=1, ready 4 cycles after valid (SLOW_WAIT=2).
REQ-033 Writes FFD7 then FFDF -> cfg[11]=1, cfg[15]=1, mapType=1; next write A=A000 -> S=000, isRAM=1.
REQ-034 R=01, read A=C000 -> S=011, slowBlock=0, ready 2 cycles after valid; read FF00 -> S=100, slowBlock=1.
REQ-035 Reads FF20, FF40, FF60, FFFE -> S=101, 110, 111, 001; IO_PAGES=1 build: FF20 -> 111.
REQ-036 valid reasserted during WAIT -> ignored, single ready; nReset pulse in WAIT after FFDF write -> cfg=0, no ready.
